fetch_unit: RTL and testbench

Instruction fetch stage: owns the architectural PC, issues reads to a multi-cycle instruction memory, and presents one fetched instruction at a time to decode through a valid/ready handshake. It sits downstream of the memory stage's next-PC output. That output arrives here as `nextPC` with `redirect`, closing the PC loop. A decoded `halt` from later stages stops fetch cleanly.

---
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding reads to instruction
// memory and hands one instruction at a time to decode. Optional FETCH_ALIGN_CHECK_EN.
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] nextPC,
    input  logic        redirect,
    input  logic        halt,
    input  logic        inst_ready,
    input  logic [15:0] imem_rdata,
    input  logic        imem_stall,
    input  logic        imem_done,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    output logic [15:0] instr,
    output logic [15:0] pcPlus2,
    output logic        inst_valid,
    output logic        halted,
    output logic        err
);
    typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_HALTED} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt, pc_inc;
    logic        drain_halt, drain_halt_nxt;
    logic        capture, drop_valid;
    logic        redirect_ok;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        align_fault;
`endif

    assign pc_inc    = pc + 16'd2;
    assign imem_addr = pc;

    // A redirect cannot revive a halted fetch, including one still draining for halt.
    assign redirect_ok = redirect && (state != S_HALTED) && !(state == S_DRAIN && drain_halt);

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_halt_nxt = drain_halt;
        capture        = 1'b0;
        drop_valid     = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        align_fault    = 1'b0;
`endif
        if (halt && state != S_HALTED) begin
            drop_valid = 1'b1;
            case (state)
                S_WAIT, S_DRAIN: begin
                    if (imem_done) begin
                        state_nxt = S_HALTED;
                    end else begin
                        state_nxt      = S_DRAIN;
                        drain_halt_nxt = 1'b1;
                    end
                end
                default: state_nxt = S_HALTED;
            endcase
        end else if (redirect_ok) begin
            drop_valid = 1'b1;
            pc_nxt     = nextPC;
            case (state)
                S_WAIT, S_DRAIN: state_nxt = imem_done ? S_REQ : S_DRAIN;
                default:         state_nxt = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (!imem_stall) state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_done) begin
                        capture   = 1'b1;
                        pc_nxt    = pc_inc;
                        state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        drop_valid = 1'b1;
                        state_nxt  = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_done) state_nxt = drain_halt ? S_HALTED : S_REQ;
                end
                default: state_nxt = state;
            endcase
        end
`ifdef FETCH_ALIGN_CHECK_EN
        // Catch an odd PC before any request for it leaves the block.
        if (state_nxt == S_REQ && pc_nxt[0]) begin
            align_fault = 1'b1;
            state_nxt   = S_HALTED;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= 16'h0000;
            drain_halt <= 1'b0;
            instr      <= 16'h0800;
            pcPlus2    <= 16'h0000;
            inst_valid <= 1'b0;
            imem_rd    <= 1'b1;
            halted     <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drain_halt <= drain_halt_nxt;
            imem_rd    <= (state_nxt == S_REQ);
            halted     <= (state_nxt == S_HALTED);
            if (capture) begin
                instr      <= imem_rdata;
                pcPlus2    <= pc_inc;
                inst_valid <= 1'b1;
            end else if (drop_valid) begin
                inst_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (align_fault) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: reactive instruction memory, stream-level reference model with a
// scoreboard queue of expected fetch addresses, directed scenarios then a random phase.
`timescale 1ns/1ps
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] nextPC;
    logic        redirect, halt, inst_ready;
    logic [15:0] imem_rdata;
    logic        imem_stall, imem_done;
    logic [15:0] imem_addr, instr, pcPlus2;
    logic        imem_rd, inst_valid, halted, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .nextPC(nextPC), .redirect(redirect), .halt(halt),
        .inst_ready(inst_ready), .imem_rdata(imem_rdata), .imem_stall(imem_stall),
        .imem_done(imem_done), .imem_addr(imem_addr), .imem_rd(imem_rd), .instr(instr),
        .pcPlus2(pcPlus2), .inst_valid(inst_valid), .halted(halted), .err(err)
    );

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h, required 0x%04h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired, required event not seen", name);
    endtask

    // Memory contents: two fixed words at the bottom, a hash elsewhere.
    function automatic logic [15:0] memf(input logic [15:0] a);
        if (a == 16'h0000) return 16'h1111;
        if (a == 16'h0002) return 16'h2222;
        return {a[10:0], a[15:11]} ^ 16'h3C5A;
    endfunction

    // Reference model: the architectural stream is model_pc, model_pc+2, ... until a
    // redirect restarts it or a halt ends it. exp_q holds upcoming fetch addresses.
    logic [15:0] exp_q[$];
    logic [15:0] model_pc;
    bit          model_halt;

    task automatic topup();
        while (!model_halt && exp_q.size() < 4) begin
            exp_q.push_back(model_pc);
            model_pc = model_pc + 16'd2;
        end
    endtask

    task automatic sb_reset();
        exp_q.delete();
        model_pc   = 16'h0000;
        model_halt = 1'b0;
    endtask

    task automatic sb_redirect(input logic [15:0] t);
        if (!model_halt) begin
            exp_q.delete();
            model_pc = t;
`ifdef FETCH_ALIGN_CHECK_EN
            if (t[0]) model_halt = 1'b1;
`endif
        end
    endtask

    task automatic sb_halt();
        exp_q.delete();
        model_halt = 1'b1;
    endtask

    task automatic cyc();
        topup();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory: one outstanding request, latency mem_min..mem_max extra cycles.
    int          mem_min = 0, mem_max = 0, stall_pct = 0;
    bit          pend;
    int          pwait;
    logic [15:0] paddr;

    initial begin
        imem_done  = 1'b0;
        imem_stall = 1'b0;
        imem_rdata = 16'hDEAD;
        pend       = 1'b0;
        pwait      = 0;
        paddr      = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (imem_done) pend = 1'b0;
                if (imem_rd && !imem_stall) begin
                    pend  = 1'b1;
                    paddr = imem_addr;
                    pwait = int'($urandom_range(mem_min, mem_max));
                end else if (pend && pwait > 0) begin
                    pwait--;
                end
            end
            @(posedge clk);
            #1;
            imem_done  = pend && (pwait == 0);
            imem_rdata = imem_done ? memf(paddr) : 16'hDEAD;
            imem_stall = (int'($urandom_range(0, 99)) < stall_pct);
        end
    end

    // Monitor: checks every accepted request and every handshaken instruction.
    int          hs_cnt = 0;
    logic [15:0] mon_a, mon_p2;

    always @(negedge clk) begin
        if (!rst) begin
            if (imem_rd && !imem_stall) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: addr 0x%04h issued, required no request", imem_addr);
                end else begin
                    check16("req_addr", imem_addr, exp_q[0]);
                end
            end
            if (inst_valid && inst_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: instr 0x%04h presented, required none", instr);
                end else begin
                    mon_a  = exp_q.pop_front();
                    mon_p2 = mon_a + 16'd2;
                    check16("instr", instr, memf(mon_a));
                    check16("pcPlus2", pcPlus2, mon_p2);
                end
            end
            if (halted) check1("rd_while_halted", imem_rd, 1'b0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          n;
    int          hs_start;
    logic [15:0] rnd_t;

    initial begin
        rst        = 1'b1;
        redirect   = 1'b0;
        halt       = 1'b0;
        inst_ready = 1'b0;
        nextPC     = 16'h0000;
        sb_reset();

        // Reset held two cycles
        cyc();
        cyc();
        check16("rst_instr", instr, 16'h0800);
        check16("rst_pcPlus2", pcPlus2, 16'h0000);
        check16("rst_addr", imem_addr, 16'h0000);
        check1("rst_valid", inst_valid, 1'b0);
        check1("rst_halted", halted, 1'b0);
        check1("rst_err", err, 1'b0);
        rst        = 1'b0;
        inst_ready = 1'b1;

        // Zero-wait memory, decode always ready: one instruction every 3 cycles
        for (int k = 1; k <= 9; k++) begin
            cyc();
            check1("valid_cadence", inst_valid, (k % 3) == 2);
            if (k == 2) begin
                check16("first_instr", instr, 16'h1111);
                check16("first_pcPlus2", pcPlus2, 16'h0002);
            end
            if (k == 5) begin
                check16("second_instr", instr, 16'h2222);
                check16("second_pcPlus2", pcPlus2, 16'h0004);
            end
        end

        // Decode back-pressure: output held, no new request
        inst_ready = 1'b0;
        n = 0;
        while (!inst_valid && n < 10) begin cyc(); n++; end
        if (n >= 10) timeout("hold_wait");
        for (int i = 0; i < 3; i++) begin
            check1("hold_valid", inst_valid, 1'b1);
            check16("hold_instr", instr, memf(16'h0006));
            check16("hold_pcPlus2", pcPlus2, 16'h0008);
            check1("hold_no_rd", imem_rd, 1'b0);
            cyc();
        end
        inst_ready = 1'b1;
        cyc();
        check1("after_ready_rd", imem_rd, 1'b1);
        check1("after_ready_valid", inst_valid, 1'b0);
        check16("after_ready_addr", imem_addr, 16'h0008);

        // Redirect in WAIT coinciding with imem_done
        n = 0;
        while (!imem_rd && n < 10) begin cyc(); n++; end
        if (n >= 10) timeout("req_wait");
        cyc();
        redirect   = 1'b1;
        nextPC     = 16'h0040;
        inst_ready = 1'b0;
        sb_redirect(16'h0040);
        cyc();
        redirect = 1'b0;
        check1("redir_valid", inst_valid, 1'b0);
        check1("redir_rd", imem_rd, 1'b1);
        check16("redir_addr", imem_addr, 16'h0040);

        // Redirect to 0xFFFE from HOLD, then PC wraps
        n = 0;
        while (!inst_valid && n < 10) begin cyc(); n++; end
        if (n >= 10) timeout("hold40_wait");
        redirect = 1'b1;
        nextPC   = 16'hFFFE;
        sb_redirect(16'hFFFE);
        cyc();
        redirect   = 1'b0;
        inst_ready = 1'b1;
        n = 0;
        while (!inst_valid && n < 10) begin cyc(); n++; end
        if (n >= 10) timeout("wrap_wait");
        check16("wrap_instr", instr, memf(16'hFFFE));
        check16("wrap_pcPlus2", pcPlus2, 16'h0000);
        cyc();
        check1("wrap_rd", imem_rd, 1'b1);
        check16("wrap_addr", imem_addr, 16'h0000);

        // Halt in WAIT with imem_done two cycles late
        mem_min = 2;
        mem_max = 2;
        cyc();
        halt       = 1'b1;
        inst_ready = 1'b0;
        sb_halt();
        cyc();
        halt = 1'b0;
        check1("drain1_halted", halted, 1'b0);
        check1("drain1_rd", imem_rd, 1'b0);
        check1("drain1_valid", inst_valid, 1'b0);
        cyc();
        check1("drain2_halted", halted, 1'b0);
        cyc();
        check1("halted_set", halted, 1'b1);
        redirect = 1'b1;
        nextPC   = 16'h0100;
        sb_redirect(16'h0100);
        cyc();
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check1("halted_stays", halted, 1'b1);
            check1("halted_valid", inst_valid, 1'b0);
            cyc();
        end

        // Reset leaves HALTED and returns PC to zero
        rst = 1'b1;
        sb_reset();
        mem_min = 0;
        mem_max = 0;
        cyc();
        cyc();
        check16("rerst_addr", imem_addr, 16'h0000);
        check1("rerst_halted", halted, 1'b0);
        check1("rerst_rd", imem_rd, 1'b1);
        rst = 1'b0;

        // Random traffic: stalls, variable latency, back-pressure, redirects
        stall_pct = 25;
        mem_max   = 3;
        hs_start  = hs_cnt;
        for (int i = 0; i < 1500; i++) begin
            redirect   = 1'b0;
            inst_ready = (int'($urandom_range(0, 99)) < 70);
            if (!imem_rd && int'($urandom_range(0, 99)) < 6) begin
                rnd_t = ($urandom_range(0, 3) == 0) ? 16'hFFFC : (16'($urandom) & 16'hFFFE);
                redirect   = 1'b1;
                nextPC     = rnd_t;
                inst_ready = 1'b0;
                sb_redirect(rnd_t);
            end
            cyc();
        end
        redirect = 1'b0;
        check1("random_progress", (hs_cnt - hs_start) >= 100, 1'b1);

        // Odd redirect target
        stall_pct  = 0;
        mem_max    = 0;
        inst_ready = 1'b0;
        n = 0;
        while (!inst_valid && n < 30) begin cyc(); n++; end
        if (n >= 30) timeout("align_wait");
        redirect = 1'b1;
        nextPC   = 16'h0041;
        sb_redirect(16'h0041);
        cyc();
        redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        check1("align_err", err, 1'b1);
        check1("align_halted", halted, 1'b1);
        check1("align_no_rd", imem_rd, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check1("align_stays_halted", halted, 1'b1);
            check1("align_err_sticky", err, 1'b1);
        end
`else
        check1("noalign_err", err, 1'b0);
        check1("noalign_rd", imem_rd, 1'b1);
        check16("noalign_addr", imem_addr, 16'h0041);
        inst_ready = 1'b1;
        n = 0;
        while (!inst_valid && n < 10) begin cyc(); n++; end
        if (n >= 10) timeout("noalign_fetch");
        check16("noalign_instr", instr, memf(16'h0041));
        check16("noalign_pcPlus2", pcPlus2, 16'h0043);
`endif
        inst_ready = 1'b0;
        cyc();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
